// File: rtl/muldiv_seq_unit_if.sv
// Operand/result handshake bundle for muldiv_seq_unit; master = EX stage, slave = unit.
// Both directions use valid/ready; the unit holds one op in flight at most.
interface muldiv_seq_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      md_op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, md_op, data1, data2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, md_op, data1, data2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_seq_unit.sv
// RV32M mul/div, radix-2 iterative; MULDIV_FAST_MUL_EN selects a one-cycle array multiplier.
// Latency: XLEN+1 edges from accept (1 edge for div-by-zero/overflow, and fast multiply).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts.
module muldiv_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  muldiv_seq_unit_if.slave   io
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   hi_q, lo_q, b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  // Operand decode at the accept edge
  logic              accept;
  logic              in_is_div, in_sgn1, in_sgn2, s1, s2, in_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              fast_take;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] fast_prod;
  logic              last_step;

  always_comb begin
    accept    = io.in_valid && (state_q == ST_IDLE) && !flush;
    in_is_div = io.md_op[2];
    in_sgn1   = (io.md_op == OP_MULH) || (io.md_op == OP_MULHSU) ||
                (io.md_op == OP_DIV)  || (io.md_op == OP_REM);
    in_sgn2   = (io.md_op == OP_MULH) || (io.md_op == OP_DIV) || (io.md_op == OP_REM);
    s1        = in_sgn1 && io.data1[XLEN-1];
    s2        = in_sgn2 && io.data2[XLEN-1];
    mag1      = s1 ? -io.data1 : io.data1;
    mag2      = s2 ? -io.data2 : io.data2;
    // Remainder follows the dividend; quotient and products follow sign difference
    in_neg    = (io.md_op == OP_REM) ? s1 : (s1 ^ s2);
    div_zero  = in_is_div && (io.data2 == '0);
    div_ovf   = ((io.md_op == OP_DIV) || (io.md_op == OP_REM)) &&
                (io.data1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.data2 == '1);
    special   = div_zero || div_ovf;
    if (div_zero) begin
      special_res = io.md_op[1] ? io.data1 : '1;
    end else begin
      special_res = io.md_op[1] ? '0 : io.data1;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] fast_a, fast_b;
  assign fast_a    = {{XLEN{s1}}, io.data1};
  assign fast_b    = {{XLEN{s2}}, io.data2};
  assign fast_prod = fast_a * fast_b;
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_prod = '0;
`endif

  assign fast_take = FAST_MUL && !in_is_div;
  assign fast_res  = (io.md_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign last_step = (cnt_q == CNT_W'(XLEN-1));

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select, applied on the final step edge
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -step_lo : step_lo;
    rem_fix  = neg_q ? -step_hi : step_hi;
    case (op_q)
      3'd0:          final_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          final_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    final_res = quot_fix;
      default:       final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (special || fast_take) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last_step) state_d = ST_DONE;
      ST_DONE: if (io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Handshake outputs decode registered state only
  always_comb begin
    io.in_ready  = (state_q == ST_IDLE);
    io.out_valid = (state_q == ST_DONE);
  end

  assign io.result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= io.md_op;
            neg_q <= in_neg;
            hi_q  <= '0;
            lo_q  <= in_is_div ? mag1 : mag2;
            b_q   <= in_is_div ? mag2 : mag1;
            cnt_q <= '0;
            if (special) begin
              result_q <= special_res;
            end else if (fast_take) begin
              result_q <= fast_res;
            end
          end
        end
        ST_BUSY: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (last_step) begin
            cnt_q    <= '0;
            result_q <= final_res;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
